window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the mean filter stage. It accepts a raster-order pixel stream, one pixel per `in_valid`, and buffers the two previous image lines internally. It presents a registered 3x3 window P1..P9 with a valid strobe. P1..P4 and P6..P9 feed the filter's neighbour inputs. P5 is the centre pixel for downstream noise detection and replacement.

## Interface
- `IMG_WIDTH`, default 512: pixels per line, ≥ 3.
- `IMG_HEIGHT`, default 512: lines per frame, ≥ 3.
- `DATA_W`, default 8: pixel width; the filter path uses 8.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the pixel on `in_pixel` is accepted this cycle.
- `in_pixel`  in  DATA_W  raster-order pixel.
- `in_sof`  in  1  qualified by `in_valid`: this pixel is (row 0, col 0).
- `P1`..`P9`  out  DATA_W each  window; rows top to bottom: P1 P2 P3 / P4 P5 P6 / P7 P8 P9.
- `out_valid`  out  1  the window is fully inside the image and new this cycle.
- `out_sof`  out  1  first window of the frame (centre at (1,1)).
- `out_eol`  out  1  last window of a line (centre col = IMG_WIDTH-2).

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the pixel accepted this cycle. Counter width is $clog2 of the bound.
- On `in_valid`, `col` increments. At IMG_WIDTH-1, `col` wraps to 0 and `row` increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0 (next frame).
- `in_valid && in_sof` forces the current pixel's position to (0,0), whatever the counter values. Counters then advance to (0,1). This is the resync mechanism; no error flag.
- Two line buffers of IMG_WIDTH x DATA_W, asynchronous read, synchronous write, addressed by `col`:
  - LB0 holds line r-1 and LB1 holds line r-2.
  - On `in_valid`: `LB1[col] <= LB0[col]`; `LB0[col] <= in_pixel`.
- Window shift on `in_valid` only. Each row shifts left and takes a new right column:
  - P1<=P2, P2<=P3, P3<=LB1[col]
  - P4<=P5, P5<=P6, P6<=LB0[col]
  - P7<=P8, P8<=P9, P9<=in_pixel
- For accepted pixel (r,c), the resulting window is centred on (r-1,c-1). P1 = pixel(r-2,c-2) and P9 = pixel(r,c).
- `out_valid <= in_valid && r ≥ 2 && c ≥ 2`, where (r,c) is the post-resync position.
- `out_sof <= out_valid-condition && r==2 && c==2`.
- `out_eol <= out_valid-condition && c==IMG_WIDTH-1`.
- Windows straddling line or frame edges are never flagged valid. No border padding is applied; the downstream stage sees only interior centres.
- Per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows.

## Timing
- Latency: 1 cycle. Window and flags for the pixel accepted in cycle n are on the outputs in cycle n+1.
- Throughput: one window per clock with `in_valid` held high. There is no backpressure; the downstream stage is combinational.
- Cycles with `in_valid`=0:
  - window, counters and line buffers hold;
  - `out_valid`, `out_sof` and `out_eol` are 0 (single-cycle strobes).
- Reset values, applied asynchronously on `rst`: `col`=0, `row`=0, P1..P9=0, `out_valid`=`out_sof`=`out_eol`=0.
  - Line buffers are not reset. Their stale contents are masked because rows 0–1 never produce `out_valid`.
- Reset mid-frame: the next accepted pixel is (0,0). The first valid window comes 2*IMG_WIDTH+3 accepted pixels later.
- Back-to-back frames: the new frame's rows 0–1 produce no `out_valid`. The first window of frame k+1 contains only frame k+1 pixels.
- `in_sof` on a pixel where the counters already read (0,0) has no extra effect.

## Test plan
Use IMG_WIDTH=8, IMG_HEIGHT=6, and pixel value = (row*16+col) mod 256 throughout.
- Continuous frame: 48 pixels, `in_valid` held high. Require:
  - 24 `out_valid` pulses;
  - first window, one cycle after pixel (2,2): P1..P9 = 00,01,02,10,11,12,20,21,22, with `out_sof`=1;
  - `out_eol` on the windows for pixels (r,7) with P9=r*16+7;
  - last window P9=0x57.
- Random `in_valid` gaps (about 50% duty) on the same frame. Require an identical sequence of 24 windows, and outputs held with strobes low during gaps.
- Two back-to-back frames, second offset by +0x80:
  - `out_valid` stays low for the second frame's first 18 pixels;
  - its first window is P1=0x80 … P9=0xA2.
- Resync: assert `in_sof` on the pixel while the counters are at (3,4), then send a full frame. Require:
  - no `out_valid` until new pixel (2,2);
  - then the same 24 windows as the continuous-frame test.
- Reset asserted asynchronously mid-cycle at pixel (4,5). Require:
  - all outputs 0 immediately;
  - after release, a fresh frame yields the 24 expected windows and no window mixes pre-reset data.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// -----------------------------------------------------------------------------
// window_3x3_gen_if
//
// Purpose: stream bundle between a raster pixel source, the 3x3 window
// generator and its downstream filter stage.
//
// Handshake: in_valid qualifies in_pixel and in_sof in the same cycle. There is
// no ready: the generator accepts every valid pixel. out_valid, out_sof and
// out_eol are single-cycle strobes that qualify P1..P9 in the same cycle.
//
// Signals:
//   in_valid   source -> generator   pixel accepted this cycle
//   in_pixel   source -> generator   raster-order pixel (DATA_W)
//   in_sof     source -> generator   pixel is (row 0, col 0); needs in_valid
//   P1..P9     generator -> sink     window, rows top to bottom
//                                    P1 P2 P3 / P4 P5 P6 / P7 P8 P9
//   out_valid  generator -> sink     window fully inside image, new this cycle
//   out_sof    generator -> sink     first window of the frame (centre (1,1))
//   out_eol    generator -> sink     last window of a line
//
// Modports: master = pixel source / window consumer (bench side),
//           slave  = the window generator.
// -----------------------------------------------------------------------------
interface window_3x3_gen_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_pixel;
    logic              in_sof;

    logic [DATA_W-1:0] P1;
    logic [DATA_W-1:0] P2;
    logic [DATA_W-1:0] P3;
    logic [DATA_W-1:0] P4;
    logic [DATA_W-1:0] P5;
    logic [DATA_W-1:0] P6;
    logic [DATA_W-1:0] P7;
    logic [DATA_W-1:0] P8;
    logic [DATA_W-1:0] P9;
    logic              out_valid;
    logic              out_sof;
    logic              out_eol;

    modport master (
        output in_valid,
        output in_pixel,
        output in_sof,
        input  P1, P2, P3, P4, P5, P6, P7, P8, P9,
        input  out_valid,
        input  out_sof,
        input  out_eol
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  in_sof,
        output P1, P2, P3, P4, P5, P6, P7, P8, P9,
        output out_valid,
        output out_sof,
        output out_eol
    );
endinterface

// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
//
// Purpose: streaming 3x3 neighbourhood generator. Accepts a raster-order pixel
// stream, keeps the two previous image lines in internal line buffers and
// presents a registered 3x3 window with valid / start-of-frame / end-of-line
// strobes. Only windows whose centre lies strictly inside the image are
// flagged valid; no border padding is produced.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   s          slave modport of window_3x3_gen_if (pixel in, window out)
//   dbg_col_o  out  column counter (position of the next expected pixel)
//   dbg_row_o  out  row counter (position of the next expected pixel)
//
// Latency: the window and strobes for a pixel accepted in cycle n appear in
// cycle n+1. Cycles without in_valid hold window, counters and line buffers
// and drop all strobes.
// -----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 8,
    localparam int COL_W     = $clog2(IMG_WIDTH),
    localparam int ROW_W     = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    window_3x3_gen_if.slave  s,
    output logic [COL_W-1:0] dbg_col_o,
    output logic [ROW_W-1:0] dbg_row_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Position of the pixel on the bus this cycle after resync: in_sof
    // overrides whatever the counters hold.
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic             col_last;
    logic             row_last;
    logic             interior;

    // Registered strobes
    logic valid_q, valid_d;
    logic sof_q,   sof_d;
    logic eol_q,   eol_d;

    always_comb begin
        pos_col  = s.in_sof ? '0 : col_q;
        pos_row  = s.in_sof ? '0 : row_q;
        col_last = (pos_col == COL_LAST);
        row_last = (pos_row == ROW_LAST);

        col_d = col_q;
        row_d = row_q;
        if (s.in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end

        // The window for pixel (r,c) is centred on (r-1,c-1); it lies fully
        // inside the image only when r and c are both at least 2.
        interior = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
        valid_d  = s.in_valid && interior;
        sof_d    = valid_d && (pos_row == ROW_TWO) && (pos_col == COL_TWO);
        eol_d    = valid_d && col_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds line r-1, lb1 holds line r-2.
    // Asynchronous read, synchronous write, both addressed by the
    // post-resync column. Not reset: rows 0 and 1 of every frame overwrite
    // them before any window is flagged valid.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    assign lb0_rd = lb0_mem[pos_col];
    assign lb1_rd = lb1_mem[pos_col];

    always_ff @(posedge clk) begin
        if (s.in_valid) begin
            lb1_mem[pos_col] <= lb0_rd;
            lb0_mem[pos_col] <= s.in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Window shift register: each row shifts left and takes a new right
    // column from lb1 (top), lb0 (middle) and the incoming pixel (bottom).
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] p1_q, p2_q, p3_q;
    logic [DATA_W-1:0] p4_q, p5_q, p6_q;
    logic [DATA_W-1:0] p7_q, p8_q, p9_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            p4_q <= '0;
            p5_q <= '0;
            p6_q <= '0;
            p7_q <= '0;
            p8_q <= '0;
            p9_q <= '0;
        end else if (s.in_valid) begin
            p1_q <= p2_q;
            p2_q <= p3_q;
            p3_q <= lb1_rd;
            p4_q <= p5_q;
            p5_q <= p6_q;
            p6_q <= lb0_rd;
            p7_q <= p8_q;
            p8_q <= p9_q;
            p9_q <= s.in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s.P1        = p1_q;
    assign s.P2        = p2_q;
    assign s.P3        = p3_q;
    assign s.P4        = p4_q;
    assign s.P5        = p5_q;
    assign s.P6        = p6_q;
    assign s.P7        = p7_q;
    assign s.P8        = p8_q;
    assign s.P9        = p9_q;
    assign s.out_valid = valid_q;
    assign s.out_sof   = sof_q;
    assign s.out_eol   = eol_q;

    assign dbg_col_o   = col_q;
    assign dbg_row_o   = row_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_gen
//
// Directed bench for window_3x3_gen with an 8x6 image and pixel value
// (base + row*16 + col) mod 256. Each driven cycle pushes its expected outputs
// onto exp_q; the entry is popped and compared on the next falling edge.
// -----------------------------------------------------------------------------
module tb_window_3x3_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.DATA_W(DW)) bus ();
    logic [2:0] dbg_col;
    logic [2:0] dbg_row;

    window_3x3_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .dbg_col_o(dbg_col),
        .dbg_row_o(dbg_row)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        cw;   // compare window
        logic        v;
        logic        s;
        logic        e;
        logic [3:0]  fr;
        logic [15:0] idx;
        logic [71:0] w;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [71:0] exp_win   = '0;
    logic        win_known = 1'b0;
    logic [3:0]  cur_fr    = '0;

    int          v_cnt     [16];
    int          eol_cnt   [16];
    int          first_idx [16];
    logic [71:0] first_win [16];
    logic [7:0]  last_p9   [16];
    logic        have_first[16];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return 8'((int'(base) + r * 16 + c) & 255);
    endfunction

    function automatic logic [71:0] win_of(input logic [7:0] base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], pix(base, r - 2 + i, c - 2 + j)};
        return w;
    endfunction

    function automatic logic [71:0] obs_win();
        return {bus.P1, bus.P2, bus.P3, bus.P4, bus.P5, bus.P6, bus.P7, bus.P8, bus.P9};
    endfunction

    task automatic check_pop();
        exp_t        e;
        logic [71:0] ow;
        e  = exp_q.pop_front();
        ow = obs_win();
        chk("out_valid", 72'(bus.out_valid), 72'(e.v));
        chk("out_sof",   72'(bus.out_sof),   72'(e.s));
        chk("out_eol",   72'(bus.out_eol),   72'(e.e));
        if (e.cw) chk("window", ow, e.w);
        if (bus.out_valid === 1'b1) begin
            v_cnt[e.fr]++;
            last_p9[e.fr] = bus.P9;
            if (!have_first[e.fr]) begin
                have_first[e.fr] = 1'b1;
                first_win[e.fr]  = ow;
                first_idx[e.fr]  = int'(e.idx);
            end
        end
        if (bus.out_eol === 1'b1) eol_cnt[e.fr]++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_px(input logic [7:0] base, input int r, input int c,
                            input logic sof, input int idx);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) check_pop();
        bus.in_valid = 1'b1;
        bus.in_pixel = pix(base, r, c);
        bus.in_sof   = sof;
        e.v   = (r >= 2) && (c >= 2);
        e.s   = e.v && (r == 2) && (c == 2);
        e.e   = e.v && (c == W - 1);
        e.fr  = cur_fr;
        e.idx = 16'(idx);
        if (e.v) begin
            exp_win   = win_of(base, r, c);
            win_known = 1'b1;
        end else begin
            win_known = 1'b0;
        end
        e.cw = e.v;
        e.w  = exp_win;
        exp_q.push_back(e);
    endtask

    // Idle cycle with junk on the data and sof lines: nothing may move.
    task automatic drive_gap();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) check_pop();
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'($urandom_range(0, 255));
        bus.in_sof   = 1'($urandom_range(0, 1));
        e.v   = 1'b0;
        e.s   = 1'b0;
        e.e   = 1'b0;
        e.fr  = cur_fr;
        e.idx = '0;
        e.cw  = win_known;
        e.w   = exp_win;
        exp_q.push_back(e);
    endtask

    task automatic send_pixels(input logic [7:0] base, input logic gaps, input int n,
                               input logic first_sof, input logic [3:0] fr);
        cur_fr = fr;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) drive_gap();
            drive_px(base, k / W, k % W, first_sof && (k == 0), k);
        end
    endtask

    task automatic frame_summary(input string pfx, input logic [3:0] fr,
                                 input logic [71:0] exp_first, input logic [7:0] exp_last);
        chk({pfx, "_valid_count"}, 72'(v_cnt[fr]), 72'd24);
        chk({pfx, "_eol_count"},   72'(eol_cnt[fr]), 72'd4);
        chk({pfx, "_first_window"}, first_win[fr], exp_first);
        chk({pfx, "_first_index"}, 72'(first_idx[fr]), 72'd18);
        chk({pfx, "_last_p9"},     72'(last_p9[fr]), 72'(exp_last));
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_window"},    obs_win(), 72'd0);
        chk({pfx, "_out_valid"}, 72'(bus.out_valid), 72'd0);
        chk({pfx, "_out_sof"},   72'(bus.out_sof), 72'd0);
        chk({pfx, "_out_eol"},   72'(bus.out_eol), 72'd0);
        chk({pfx, "_col"},       72'(dbg_col), 72'd0);
        chk({pfx, "_row"},       72'(dbg_row), 72'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int f = 0; f < 16; f++) begin
            v_cnt[f]      = 0;
            eol_cnt[f]    = 0;
            first_idx[f]  = -1;
            first_win[f]  = '0;
            last_p9[f]    = '0;
            have_first[f] = 1'b0;
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.in_sof   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1. Continuous frame
        send_pixels(8'h00, 1'b0, 48, 1'b1, 4'd1);
        drive_gap();
        frame_summary("cont", 4'd1, 72'h00_01_02_10_11_12_20_21_22, 8'h57);

        // 2. Same frame with random idle gaps
        send_pixels(8'h00, 1'b1, 48, 1'b1, 4'd2);
        drive_gap();
        frame_summary("gaps", 4'd2, 72'h00_01_02_10_11_12_20_21_22, 8'h57);

        // 3. Two back-to-back frames, second offset by 0x80
        send_pixels(8'h00, 1'b0, 48, 1'b1, 4'd3);
        send_pixels(8'h80, 1'b0, 48, 1'b1, 4'd4);
        drive_gap();
        frame_summary("b2b_f1", 4'd3, 72'h00_01_02_10_11_12_20_21_22, 8'h57);
        frame_summary("b2b_f2", 4'd4, 72'h80_81_82_90_91_92_A0_A1_A2, 8'hD7);

        // 4. Resync: abandon a frame at (3,4) with a new in_sof pixel
        send_pixels(8'h00, 1'b0, 28, 1'b1, 4'd5);
        send_pixels(8'h00, 1'b0, 48, 1'b1, 4'd6);
        drive_gap();
        frame_summary("resync", 4'd6, 72'h00_01_02_10_11_12_20_21_22, 8'h57);

        // 5. Asynchronous reset in the middle of the cycle after pixel (4,5)
        send_pixels(8'h00, 1'b0, 37, 1'b1, 4'd7);
        drive_px(8'h00, 4, 5, 1'b0, 37);
        @(posedge clk);
        #1 check_pop();
        #1 rst = 1'b1;
        #1 check_all_zero("midreset");
        exp_q.delete();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        win_known    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Fresh frame without in_sof: the reset counters alone must place it.
        send_pixels(8'h00, 1'b0, 48, 1'b0, 4'd8);
        drive_gap();
        frame_summary("after_reset", 4'd8, 72'h00_01_02_10_11_12_20_21_22, 8'h57);

        // Drain the last pending expectation
        @(negedge clk);
        while (exp_q.size() > 0) check_pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
